// File: rtl/spi_slave_sync.sv
// SPI slave (modes 0-3) with clk-domain synchronisers and a one-word tx holding register.
// Define SPI_SLAVE_ERR_FLAGS_EN to add sticky tx_underrun / frame_err outputs.
module spi_slave_sync #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    ,
    input  logic              err_clr,
    output logic              tx_underrun,
    output logic              frame_err
`endif
);

    localparam int CW = $clog2(DATA_W);
    localparam int S  = SYNC_STAGES;

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

    state_t state, state_nx;

    logic [S-1:0]      sclk_q, cs_q, mosi_q, cs_vld;
    logic              sclk_prev, cs_hi, cpol_l, cpha_l, hold_full;
    logic [DATA_W-1:0] hold_data, tx_shift, rx_shift;
    logic [DATA_W-1:0] rx_next, load_word, arm_shift;
    logic [CW-1:0]     bit_cnt;
    logic              sclk_s, cs_s, mosi_s, sclk_chg, lead, trail;
    logic              sample_ev, drive_ev, last_bit, cs_fall;
    logic              do_arm, do_sample, do_drive, do_done, do_abort;

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v,
                                                   input logic b);
        if (MSB_FIRST != 0) return {v[DATA_W-2:0], b};
        else                return {b, v[DATA_W-1:1]};
    endfunction

    function automatic logic out_bit(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
    endfunction

    assign sclk_s    = sclk_q[S-1];
    assign cs_s      = cs_q[S-1];
    assign mosi_s    = mosi_q[S-1];
    assign sclk_chg  = sclk_s ^ sclk_prev;
    assign lead      = sclk_chg && (sclk_s != cpol_l);
    assign trail     = sclk_chg && (sclk_s == cpol_l);
    assign sample_ev = cpha_l ? trail : lead;
    // cpha=0: the trailing edge that ends the previous word arrives with bit_cnt=0
    assign drive_ev  = cpha_l ? lead : (trail && (bit_cnt != '0));
    assign last_bit  = (bit_cnt == CW'(DATA_W - 1));
    // cs_hi only rises once the chain holds a real high pin sample after reset
    assign cs_fall   = cs_hi && !cs_s;
    assign rx_next   = shift_in(rx_shift, mosi_s);
    assign load_word = hold_full ? hold_data : '0;
    assign arm_shift = cpha_l ? load_word : shift_in(load_word, 1'b0);
    assign tx_ready  = !hold_full;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        do_arm    = 1'b0;
        do_sample = 1'b0;
        do_drive  = 1'b0;
        do_done   = 1'b0;
        do_abort  = 1'b0;
        unique case (state)
            IDLE: if (cs_fall) state_nx = ARMED;
            ARMED: begin
                do_arm   = 1'b1;
                state_nx = SHIFT;
            end
            SHIFT: begin
                if (cs_s) begin
                    state_nx = IDLE;
                    do_abort = (bit_cnt != '0);
                end else if (sample_ev) begin
                    do_sample = 1'b1;
                    if (last_bit) begin
                        do_done  = 1'b1;
                        state_nx = ARMED;
                    end
                end else if (drive_ev) begin
                    do_drive = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_q    <= '0;
            cs_q      <= '1;
            mosi_q    <= '0;
            cs_vld    <= '0;
            sclk_prev <= 1'b0;
            cs_hi     <= 1'b0;
            cpol_l    <= 1'b0;
            cpha_l    <= 1'b0;
            hold_full <= 1'b0;
            hold_data <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            miso      <= 1'b0;
        end else begin
            sclk_q    <= {sclk_q[S-2:0], sclk};
            cs_q      <= {cs_q[S-2:0], cs};
            mosi_q    <= {mosi_q[S-2:0], mosi};
            cs_vld    <= {cs_vld[S-2:0], 1'b1};
            sclk_prev <= sclk_s;
            cs_hi     <= cs_vld[S-1] && cs_s;
            rx_valid  <= 1'b0;
            if (tx_valid && !hold_full) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end
            if (state == IDLE && cs_fall) begin
                cpol_l <= cpol;
                cpha_l <= cpha;
            end
            if (do_arm) begin
                bit_cnt  <= '0;
                tx_shift <= arm_shift;
                if (hold_full) hold_full <= 1'b0;
                if (!cpha_l)   miso      <= out_bit(load_word);
            end
            if (do_sample) begin
                rx_shift <= rx_next;
                bit_cnt  <= bit_cnt + 1'b1;
                if (do_done) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end
            end
            if (do_drive) begin
                miso     <= out_bit(tx_shift);
                tx_shift <= shift_in(tx_shift, 1'b0);
            end
            if (do_abort) rx_shift <= '0;
            if (state_nx == IDLE) miso <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            if (err_clr) begin
                tx_underrun <= 1'b0;
                frame_err   <= 1'b0;
            end
            if (do_arm && !hold_full) tx_underrun <= 1'b1;
            if (do_abort)             frame_err   <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: SPI master model, tx holding-register model, rx scoreboard.
// Directed frames for each mode, back-to-back, abort, underrun, mid-word reset, then random frames.
`timescale 1ns/1ps
module tb_spi_slave_sync;

    localparam int W    = 8;
    localparam int HALF = 6;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sclk = 1'b0;
    logic         cs = 1'b1;
    logic         mosi = 1'b0;
    logic         cpol = 1'b0;
    logic         cpha = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         miso, tx_ready, rx_valid, busy;
    logic [W-1:0] rx_data;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    logic         err_clr = 1'b0;
    logic         tx_underrun, frame_err;
`endif

    spi_slave_sync #(.DATA_W(W), .SYNC_STAGES(2), .MSB_FIRST(1)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .cpol(cpol), .cpha(cpha), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_ERR_FLAGS_EN
        , .err_clr(err_clr), .tx_underrun(tx_underrun), .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] exp_rx[$];
    logic [W-1:0] hold_m = '0;
    bit           hold_full_m = 1'b0;
    logic [W-1:0] f_mo[3];
    logic [W-1:0] f_tw[3];
    bit           f_tv[3];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // every received word must match the oldest word the master sent
    always @(negedge clk) begin
        if (!reset && rx_valid) begin
            if (exp_rx.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_valid: got unexpected word %h expected none", rx_data);
            end else begin
                check("rx_data", rx_data, exp_rx.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [W-1:0] hold_take();
        logic [W-1:0] v;
        v = hold_full_m ? hold_m : '0;
        hold_full_m = 1'b0;
        return v;
    endfunction

    task automatic tx_write(input logic [W-1:0] w);
        @(negedge clk);
        check("tx_ready", tx_ready, !hold_full_m);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid    = 1'b0;
        hold_m      = w;
        hold_full_m = 1'b1;
    endtask

    task automatic spi_word(input logic [W-1:0] mo, input int nbits, input bit pol,
                            input bit pha, output logic [W-1:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!pha) begin
                mosi = mo[W-1-i];
                cyc(HALF);
                sclk = ~pol;
                mi = {mi[W-2:0], miso};
                cyc(HALF);
                sclk = pol;
            end else begin
                sclk = ~pol;
                mosi = mo[W-1-i];
                cyc(HALF);
                sclk = pol;
                mi = {mi[W-2:0], miso};
                cyc(HALF);
            end
        end
    endtask

    task automatic run_frame(input logic [1:0] mode, input int n, input int abort_bits,
                             input bit arm_wr, input logic [W-1:0] arm_word);
        bit           pol, pha;
        logic [W-1:0] mi, exp_mi;
        int           t;
        pol = mode[1];
        pha = mode[0];
        cyc(2);
        cpol = pol;
        cpha = pha;
        sclk = pol;
        cyc(6);
        if (f_tv[0] && !hold_full_m) tx_write(f_tw[0]);
        cs = 1'b0;
        exp_mi = hold_take();
        if (arm_wr) begin
            t = 0;
            @(negedge clk);
            while (!busy && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("busy_armed", busy, 1);
            check("tx_ready_armed", tx_ready, 1);
            tx_data  = arm_word;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid    = 1'b0;
            hold_m      = arm_word;
            hold_full_m = 1'b1;
        end
        cyc(2 * HALF);
        cpol = 1'($urandom);
        cpha = 1'($urandom);
        for (int k = 0; k < n; k++) begin
            if (k > 0) exp_mi = hold_take();
            if (k + 1 < n && f_tv[k+1] && !hold_full_m) tx_write(f_tw[k+1]);
            if (abort_bits > 0) begin
                spi_word(f_mo[0], abort_bits, pol, pha, mi);
                break;
            end
            exp_rx.push_back(f_mo[k]);
            spi_word(f_mo[k], W, pol, pha, mi);
            check($sformatf("miso_m%0d_w%0d", mode, k), mi, exp_mi);
        end
        // cs is still low after the last word, so the slave re-arms once more
        if (abort_bits == 0) void'(hold_take());
        cyc(HALF);
        cs = 1'b1;
        cyc(3 * HALF);
        if (abort_bits > 0) begin
            check("busy_after_abort", busy, 0);
            check("miso_after_abort", miso, 0);
        end
    endtask

    task automatic set_frame(input logic [W-1:0] m0, input logic [W-1:0] m1,
                             input logic [W-1:0] t0, input logic [W-1:0] t1,
                             input bit v0, input bit v1);
        f_mo[0] = m0; f_mo[1] = m1; f_mo[2] = '0;
        f_tw[0] = t0; f_tw[1] = t1; f_tw[2] = '0;
        f_tv[0] = v0; f_tv[1] = v1; f_tv[2] = 1'b0;
    endtask

`ifdef SPI_SLAVE_ERR_FLAGS_EN
    task automatic clear_errs();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("tx_underrun_clr", tx_underrun, 0);
        check("frame_err_clr", frame_err, 0);
    endtask
`endif

    initial begin
        logic [W-1:0] mi;
        int           nw, ab;
        logic [1:0]   md;

        cyc(3);
        check("rst_miso", miso, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        reset = 1'b0;
        cyc(5);

        set_frame(8'h3C, 8'h00, 8'hA5, 8'h00, 1'b1, 1'b0);
        run_frame(2'd0, 1, 0, 1'b0, 8'h00);
`ifdef SPI_SLAVE_ERR_FLAGS_EN
        clear_errs();
`endif
        for (int m = 1; m < 4; m++) begin
            set_frame(8'h7E, 8'h00, 8'h81, 8'h00, 1'b1, 1'b0);
            run_frame(2'(m), 1, 0, 1'b0, 8'h00);
        end
`ifdef SPI_SLAVE_ERR_FLAGS_EN
        check("frame_err_normal", frame_err, 0);
`endif

        set_frame(8'h5A, 8'hC3, 8'h11, 8'h22, 1'b1, 1'b1);
        run_frame(2'd0, 2, 0, 1'b0, 8'h00);

        set_frame(8'hB7, 8'h00, 8'h99, 8'h00, 1'b1, 1'b0);
        run_frame(2'd0, 1, 5, 1'b0, 8'h00);
`ifdef SPI_SLAVE_ERR_FLAGS_EN
        check("frame_err_abort", frame_err, 1);
        clear_errs();
`endif

        set_frame(8'h3C, 8'h96, 8'h00, 8'h00, 1'b0, 1'b0);
        run_frame(2'd0, 2, 0, 1'b1, 8'h6B);
`ifdef SPI_SLAVE_ERR_FLAGS_EN
        check("tx_underrun_set", tx_underrun, 1);
`endif

        // reset in the middle of a word, cs held low through release
        cpol = 1'b0;
        cpha = 1'b0;
        sclk = 1'b0;
        cyc(6);
        tx_write(8'hF0);
        cs = 1'b0;
        void'(hold_take());
        cyc(2 * HALF);
        tx_write(8'h0F);
        spi_word(8'hAA, 3, 1'b0, 1'b0, mi);
        sclk = 1'b1;
        cyc(2);
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_miso", miso, 0);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_rx_data", rx_data, 0);
        check("midrst_tx_ready", tx_ready, 1);
        hold_full_m = 1'b0;
        cyc(3);
        reset = 1'b0;
        sclk = 1'b0;
        cyc(10);
        spi_word(8'hFF, W, 1'b0, 1'b0, mi);
        cyc(10);
        check("cs_low_release_busy", busy, 0);
        cs = 1'b1;
        cyc(10);
        set_frame(8'hE1, 8'h00, 8'h4D, 8'h00, 1'b1, 1'b0);
        run_frame(2'd0, 1, 0, 1'b0, 8'h00);

        for (int f = 0; f < 20; f++) begin
            md = 2'($urandom_range(0, 3));
            nw = $urandom_range(1, 3);
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, W - 1) : 0;
            for (int i = 0; i < 3; i++) begin
                f_mo[i] = W'($urandom);
                f_tw[i] = W'($urandom);
                f_tv[i] = 1'($urandom);
            end
            run_frame(md, nw, ab, 1'b0, 8'h00);
        end

        cyc(20);
        check("rx_queue_empty", exp_rx.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_sync.md
SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the bits per SPI word (legal range 4..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser depth on sclk, cs and mosi (legal range 2..4).
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 shifts MSB first, 0 shifts LSB first.
REQ-004 clk  in  1  system clock; the design is fully synchronous to it; clk frequency SHALL be at least 4x the sclk frequency.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 sclk, cs, mosi  in  1 each  SPI pins, asynchronous to clk; cs is active-low.
REQ-007 miso  out  1  serial data out, registered.
REQ-008 cpol, cpha  in  1 each  SPI mode select.
REQ-009 tx_data  in  DATA_W, tx_valid  in  1, tx_ready  out  1  transmit holding-register handshake.
REQ-010 rx_data  out  DATA_W, rx_valid  out  1  received word, rx_valid is a 1-cycle pulse with no backpressure.
REQ-011 busy  out  1  high while a frame is active.

Function
REQ-012 sclk, cs and mosi SHALL each pass through SYNC_STAGES flops; sclk edges SHALL be detected on the synchronised signal, giving a pin-to-edge-detect latency of SYNC_STAGES+1 clk cycles.
REQ-013 The FSM SHALL have 3 states: IDLE, ARMED, SHIFT.
REQ-014 The synchronised cs falling edge SHALL move IDLE->ARMED and latch cpol/cpha for the frame; changes to cpol/cpha mid-frame SHALL be ignored.
REQ-015 ARMED SHALL last 1 cycle: it loads the shift register from the holding register if full (freeing it), or with all zeros if empty; it clears the bit counter; it drives the first bit onto miso if the latched cpha=0; then it enters SHIFT.
REQ-016 Leading edge SHALL be defined as sclk leaving its cpol idle level, and trailing edge as sclk returning to it.
REQ-017 With cpha=0, mosi SHALL be sampled on leading edges and the next bit shifted onto miso on trailing edges; with cpha=1, miso SHALL shift on leading edges and mosi SHALL be sampled on trailing edges.
REQ-018 After DATA_W samples, rx_data SHALL update and rx_valid SHALL pulse exactly 1 cycle later, and the FSM SHALL re-enter ARMED if cs is still low, giving back-to-back words.
REQ-019 tx_ready SHALL equal NOT holding-full; a tx_valid&&tx_ready write SHALL take effect on the next clk edge; an ARMED load in that same cycle SHALL see the old (empty) state, so the new word waits for the next word.
REQ-020 A cs rising edge in SHIFT SHALL discard the partial word (no rx_valid) and return the FSM to IDLE; the tx word already loaded is lost.
REQ-021 miso SHALL be 0 whenever the FSM is in IDLE; busy SHALL be 1 in ARMED and SHIFT.
REQ-022 sclk edges seen in IDLE SHALL be ignored.

Reset
REQ-023 Asserting reset SHALL immediately force: FSM=IDLE, miso=0, rx_data=0, rx_valid=0, busy=0, holding register empty (tx_ready=1), shift register and counter=0, synchronisers cleared to the cs-high/idle state.
REQ-024 If cs is low when reset is released, no frame SHALL start until cs has been high then low again (a frame already in progress is ignored).

Configuration
REQ-025 With SPI_SLAVE_ERR_FLAGS_EN defined, the block SHALL add two sticky outputs, tx_underrun (set when ARMED loads zeros) and frame_err (set on REQ-020 abort), each cleared by reset or by a 1-cycle err_clr input.
REQ-026 Without SPI_SLAVE_ERR_FLAGS_EN, those ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-027 Mode 0, DATA_W=8: tx_data=0xA5 preloaded, master sends 0x3C -> miso carries 1,0,1,0,0,1,0,1; rx_data=0x3C with a single rx_valid pulse.
REQ-028 Modes 1, 2 and 3 each with tx=0x81, master=0x7E -> master receives 0x81 and rx_data=0x7E in every mode.
REQ-029 Two back-to-back words with cs held low, tx 0x11 then 0x22 (second word written while the first shifts) -> two rx_valid pulses, and the master receives 0x11 then 0x22.
REQ-030 cs raised after 5 bits -> no rx_valid, FSM=IDLE, busy=0, and frame_err=1 when the macro is defined.
REQ-031 No tx write before a frame -> miso sends 0x00, and tx_underrun=1 when the macro is defined; a tx write in the ARMED cycle is sent in the following word.
REQ-032 Reset asserted mid-word -> all outputs take reset values the same cycle; cs still low at release -> no rx_valid until cs toggles high then low.
